// File: rtl/painterengine_gpu_displayfetch.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_displayfetch: scans a clipped texture region and streams pixels.
// Option macro PAINTERENGINE_GPU_DISPLAYFETCH_COORD_EN adds per-pixel x/y outputs.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module painterengine_gpu_displayfetch #(
  parameter int PIXEL_BYTES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_texture_address,
  input  logic [15:0] i_wire_image_width,
  input  logic [15:0] i_wire_clip_width,
  input  logic [15:0] i_wire_clip_height,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_rd_valid,
  input  logic        i_wire_rd_ready,
  output logic [31:0] o_wire_rd_address,
  input  logic        i_wire_rd_data_valid,
  input  logic [31:0] i_wire_rd_data,
  output logic        o_wire_pixel_valid,
  input  logic        i_wire_pixel_ready,
  output logic [31:0] o_wire_pixel_data,
`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_COORD_EN
  output logic [15:0] o_wire_pixel_x,
  output logic [15:0] o_wire_pixel_y,
`endif
  output logic        o_wire_pixel_last
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [31:0] c_pix_step = 32'(PIXEL_BYTES);
  localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [15:0]          r_width;
  logic [15:0]          r_height;
  logic [15:0]          r_x;
  logic [15:0]          r_y;
  logic [31:0]          r_row_step;
  logic [31:0]          r_row_base;
  logic [31:0]          r_addr;
  logic [31:0]          r_left;
  logic [c_cnt_w-1:0]   r_outst;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [31:0]          r_mem [FIFO_DEPTH];

  logic [c_cnt_w:0]     w_inflight;
  logic                 w_rd_valid;
  logic                 w_rd_hs;
  logic                 w_pix_valid;
  logic                 w_pop;
  logic                 w_last_col;
  logic                 w_last_row;
  logic [31:0]          w_next_row;

  // Credit covers both in-flight reads and buffered pixels so returns never overflow.
  assign w_inflight  = (c_cnt_w + 1)'(r_outst) + (c_cnt_w + 1)'(r_count);
  assign w_rd_valid  = (r_state == S_FETCH) && (w_inflight < c_depth);
  assign w_rd_hs     = w_rd_valid && i_wire_rd_ready;
  assign w_pix_valid = (r_count != '0);
  assign w_pop       = w_pix_valid && i_wire_pixel_ready;
  assign w_last_col  = (r_x == r_width - 16'd1);
  assign w_last_row  = (r_y == r_height - 16'd1);
  assign w_next_row  = r_row_base + r_row_step;

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_width    <= '0;
      r_height   <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_row_step <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_left     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) r_left <= r_left - 32'd1;
      case (r_state)
        S_IDLE: begin
          if (i_wire_start) begin
            r_width    <= i_wire_clip_width;
            r_height   <= i_wire_clip_height;
            r_row_step <= 32'(i_wire_image_width) * c_pix_step;
            r_row_base <= i_wire_texture_address;
            r_addr     <= i_wire_texture_address;
            r_x        <= '0;
            r_y        <= '0;
            r_left     <= 32'(i_wire_clip_width) * 32'(i_wire_clip_height);
            if (i_wire_clip_width == 16'd0 || i_wire_clip_height == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_busy  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (w_rd_hs) begin
            if (w_last_col) begin
              r_x        <= '0;
              r_row_base <= w_next_row;
              r_addr     <= w_next_row;
              if (w_last_row) r_state <= S_DRAIN;
              else            r_y     <= r_y + 16'd1;
            end else begin
              r_x    <= r_x + 16'd1;
              r_addr <= r_addr + c_pix_step;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && r_left == 32'd1) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      r_outst <= '0;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      case ({w_rd_hs, i_wire_rd_data_valid})
        2'b10:   r_outst <= r_outst + c_cnt_w'(1);
        2'b01:   r_outst <= r_outst - c_cnt_w'(1);
        default: ;
      endcase
      case ({i_wire_rd_data_valid, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: ;
      endcase
      if (i_wire_rd_data_valid) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)                r_rptr <= r_rptr + c_ptr_w'(1);
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_rd_data_valid) r_mem[r_wptr] <= i_wire_rd_data;
  end

`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_COORD_EN
  logic [15:0] r_px;
  logic [15:0] r_py;

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      r_px <= '0;
      r_py <= '0;
    end else if (r_state == S_IDLE && i_wire_start) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_pop) begin
      if (r_px == r_width - 16'd1) begin
        r_px <= '0;
        r_py <= r_py + 16'd1;
      end else begin
        r_px <= r_px + 16'd1;
      end
    end
  end

  assign o_wire_pixel_x = r_px;
  assign o_wire_pixel_y = r_py;
`endif

  assign o_wire_busy        = r_busy;
  assign o_wire_done        = r_done;
  assign o_wire_rd_valid    = w_rd_valid;
  assign o_wire_rd_address  = r_addr;
  assign o_wire_pixel_valid = w_pix_valid;
  assign o_wire_pixel_data  = r_mem[r_rptr];
  assign o_wire_pixel_last  = w_pix_valid && (r_left == 32'd1);

endmodule

`default_nettype wire

// File: tb/tb_painterengine_gpu_displayfetch.sv
// ----------------------------------------------------------------------------
// tb_painterengine_gpu_displayfetch: scoreboard bench with a one-cycle memory model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_painterengine_gpu_displayfetch;

  localparam int c_pix_bytes = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] tex_addr = '0;
  logic [15:0] img_w = '0;
  logic [15:0] clip_w = '0;
  logic [15:0] clip_h = '0;
  logic        busy, done, rd_valid, pixel_valid, pixel_last;
  logic        rd_ready = 1'b1;
  logic [31:0] rd_address;
  logic        rd_data_valid = 1'b0;
  logic [31:0] rd_data = '0;
  logic        pixel_ready = 1'b1;
  logic [31:0] pixel_data;
`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_COORD_EN
  logic [15:0] pix_x, pix_y;
`endif

  painterengine_gpu_displayfetch #(.PIXEL_BYTES(c_pix_bytes), .FIFO_DEPTH(4)) dut (
    .i_wire_clock          (clk),
    .i_wire_reset          (rst),
    .i_wire_start          (start),
    .i_wire_texture_address(tex_addr),
    .i_wire_image_width    (img_w),
    .i_wire_clip_width     (clip_w),
    .i_wire_clip_height    (clip_h),
    .o_wire_busy           (busy),
    .o_wire_done           (done),
    .o_wire_rd_valid       (rd_valid),
    .i_wire_rd_ready       (rd_ready),
    .o_wire_rd_address     (rd_address),
    .i_wire_rd_data_valid  (rd_data_valid),
    .i_wire_rd_data        (rd_data),
    .o_wire_pixel_valid    (pixel_valid),
    .i_wire_pixel_ready    (pixel_ready),
    .o_wire_pixel_data     (pixel_data),
`ifdef PAINTERENGINE_GPU_DISPLAYFETCH_COORD_EN
    .o_wire_pixel_x        (pix_x),
    .o_wire_pixel_y        (pix_y),
`endif
    .o_wire_pixel_last     (pixel_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tb_check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_last[$];

  // rd_mode / pix_mode: 0 = always ready, 1 = held low, 2 = random
  int rd_mode  = 0;
  int pix_mode = 0;
  int cyc = 0;
  int n_done, n_rd_hs, n_rv, n_pv, n_pix, pix_first, pix_lastc;

  task automatic clr_stats();
    n_done = 0; n_rd_hs = 0; n_rv = 0; n_pv = 0; n_pix = 0;
    pix_first = -1; pix_lastc = -1;
  endtask

  // Memory model, pixel sink and scoreboard, all evaluated on the falling edge.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    pend = 1'b0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend = 1'b0;
        rd_data_valid = 1'b0;
        continue;
      end
      rd_data_valid = pend;
      rd_data = pend ? mem_word(pend_addr) : 32'h0;
      pend = 1'b0;
      rd_ready    = (rd_mode == 0) ? 1'b1 : (rd_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      pixel_ready = (pix_mode == 0) ? 1'b1 : (pix_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (done) n_done++;
      if (pixel_valid) n_pv++;
      if (rd_valid) begin
        n_rv++;
        if (q_addr.size() == 0) begin
          tb_check("rd_unexpected", 32'd1, 32'd0);
        end else if (rd_ready) begin
          tb_check("rd_addr", rd_address, q_addr.pop_front());
          n_rd_hs++;
          pend = 1'b1;
          pend_addr = rd_address;
        end else begin
          tb_check("rd_addr_stall", rd_address, q_addr[0]);
        end
      end
      if (pixel_valid && pixel_ready) begin
        if (q_data.size() == 0) begin
          tb_check("pix_unexpected", 32'd1, 32'd0);
        end else begin
          tb_check("pix_data", pixel_data, q_data.pop_front());
          tb_check("pix_last", 32'(pixel_last), 32'(q_last.pop_front()));
        end
        if (pix_first < 0) pix_first = cyc;
        pix_lastc = cyc;
        n_pix++;
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                             input logic [15:0] w, input logic [15:0] h);
    logic [31:0] a;
    for (int y = 0; y < int'(h); y++) begin
      for (int x = 0; x < int'(w); x++) begin
        a = base + (32'(y) * 32'(stride) + 32'(x)) * 32'(c_pix_bytes);
        q_addr.push_back(a);
        q_data.push_back(mem_word(a));
        q_last.push_back((y == int'(h) - 1) && (x == int'(w) - 1));
      end
    end
    @(negedge clk);
    tex_addr = base; img_w = stride; clip_w = w; clip_h = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) tb_check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic end_frame(input string tag);
    tb_check({tag, "_addr_left"}, 32'(q_addr.size()), 32'd0);
    tb_check({tag, "_pix_left"}, 32'(q_data.size()), 32'd0);
    tb_check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    tb_check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int first_k;
    clr_stats();
    rst = 1'b1;
    #12;
    tb_check("rst_busy", 32'(busy), 32'd0);
    tb_check("rst_done", 32'(done), 32'd0);
    tb_check("rst_rd_valid", 32'(rd_valid), 32'd0);
    tb_check("rst_pix_valid", 32'(pixel_valid), 32'd0);
    tb_check("rst_pix_last", 32'(pixel_last), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // 2x2 clip inside a 4-pixel-wide texture
    clr_stats();
    start_frame(32'h0000_1000, 16'd4, 16'd2, 16'd2);
    tb_check("f1_busy", 32'(busy), 32'd1);
    wait_done(200);
    end_frame("f1");
    tb_check("f1_no_bubble", 32'(pix_lastc - pix_first), 32'd3);

    // zero-width clip: immediate done, nothing fetched
    clr_stats();
    start_frame(32'h0000_2000, 16'd4, 16'd0, 16'd5);
    first_k = done ? 1 : 0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      if (first_k == 0 && done) first_k = k;
    end
    tb_check("zero_done_lat", 32'(first_k >= 1 && first_k <= 2), 32'd1);
    tb_check("zero_done_cnt", 32'(n_done), 32'd1);
    tb_check("zero_rd_valid", 32'(n_rv), 32'd0);
    tb_check("zero_pix_valid", 32'(n_pv), 32'd0);

    // sink stalled: credit limits requests to the FIFO depth
    clr_stats();
    pix_mode = 1;
    start_frame(32'h0000_3000, 16'd8, 16'd8, 16'd1);
    repeat (20) @(negedge clk);
    tb_check("stall_req_cnt", 32'(n_rd_hs), 32'd4);
    tb_check("stall_rd_valid", 32'(rd_valid), 32'd0);
    pix_mode = 0;
    wait_done(200);
    end_frame("stall");
    tb_check("stall_req_total", 32'(n_rd_hs), 32'd8);

    // random read and pixel backpressure, 8x3
    clr_stats();
    rd_mode = 2; pix_mode = 2;
    start_frame(32'h2000_0000, 16'd10, 16'd8, 16'd3);
    wait_done(1000);
    end_frame("rand");
    rd_mode = 0; pix_mode = 0;

    // full-rate 8x3 across row wraps
    clr_stats();
    start_frame(32'h0000_8000, 16'd9, 16'd8, 16'd3);
    wait_done(300);
    end_frame("rate");
    tb_check("rate_no_bubble", 32'(pix_lastc - pix_first), 32'd23);

    // 32-bit address wrap-around
    clr_stats();
    start_frame(32'hFFFF_FFF8, 16'd2, 16'd2, 16'd2);
    wait_done(200);
    end_frame("wrap");

    // reset in the middle of a 16x16 fetch
    clr_stats();
    start_frame(32'h0000_4000, 16'd16, 16'd16, 16'd16);
    repeat (12) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    tb_check("mid_rst_busy", 32'(busy), 32'd0);
    tb_check("mid_rst_pix_valid", 32'(pixel_valid), 32'd0);
    tb_check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    q_addr.delete(); q_data.delete(); q_last.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    clr_stats();
    start_frame(32'h0000_5000, 16'd3, 16'd3, 16'd2);
    wait_done(200);
    end_frame("post_rst");

    // start re-pulsed while busy is ignored
    clr_stats();
    start_frame(32'h0000_6000, 16'd4, 16'd4, 16'd2);
    repeat (2) @(negedge clk);
    tex_addr = 32'h0000_9000; clip_w = 16'd1; clip_h = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);
    repeat (5) @(negedge clk);
    end_frame("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
